p_word_serializer: RTL and testbench

//  Read-side consumer of the 48-bit registered P/PCOUT word produced by the DSP48A1 pipeline stages.

---
 rtl/dsp48_pkg.sv | 22 ++
 rtl/p_word_serializer.sv | 106 ++++++++++
 tb/tb_p_word_serializer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48_pkg.sv
// dsp48_pkg: constants, helpers and encodings shared by the DSP48A1
// read-side blocks.
//   P_WIDTH  width of the registered P/PCOUT word
//   SER_BEAT default narrow-bus beat width used by the serializer
//   nbeats() number of beats needed to carry one word
//   ser_state_e  1-bit serializer FSM state encoding
package dsp48_pkg;

  localparam int P_WIDTH  = 48;
  localparam int SER_BEAT = 16;

  // Number of BEAT-wide slices in a WIDTH-wide word.
  function automatic int nbeats(input int width, input int beat);
    return width / beat;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/p_word_serializer.sv
// p_word_serializer: takes one WIDTH-bit P word per valid/ready handshake
// and drains it as WIDTH/BEAT beats on a valid/ready/last stream.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   ce                   clock enable; low freezes everything, in_ready=0
//   in_data/in_valid/in_ready    word input handshake
//   out_data/out_valid/out_last/out_ready  beat output handshake
//   busy                 a word is held and not yet drained
module p_word_serializer
  import dsp48_pkg::*;
#(
  parameter int WIDTH     = P_WIDTH,
  parameter int BEAT      = SER_BEAT,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BEAT-1:0]  out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NBEATS = nbeats(WIDTH, BEAT);
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if ((WIDTH % BEAT) != 0) begin : g_bad_width
    $error("p_word_serializer: WIDTH must be a multiple of BEAT");
  end

  ser_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] hold_r, hold_nxt_s;
  logic             fire_s, last_s, acc_s;

  // The held word is shifted one beat per fire, so the current beat always
  // sits in the same fixed slice and out_data is a plain register slice.
  assign out_data  = (MSB_FIRST != 0) ? hold_r[WIDTH-1 -: BEAT] : hold_r[BEAT-1:0];
  assign out_valid = (state_r == SHIFT);
  assign busy      = (state_r == SHIFT);
  assign last_s    = (state_r == SHIFT) && (cnt_r == CNT_W'(NBEATS - 1));
  assign out_last  = last_s;
  assign fire_s    = ce & out_valid & out_ready;
  // Ready while idle, or in the cycle the last beat leaves: this lets the
  // next word load with no bubble. Held low during reset.
  assign in_ready  = rst_n & ce & ((state_r == IDLE) | (fire_s & last_s));
  assign acc_s     = in_valid & in_ready;

  // Next-state, counter and holding-register logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = {CNT_W{1'b0}};
          hold_nxt_s  = in_data;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (fire_s && last_s) begin
          if (acc_s) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            hold_nxt_s = in_data;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        end else if (fire_s) begin
          cnt_nxt_s  = cnt_r + CNT_W'(1);
          hold_nxt_s = (MSB_FIRST != 0) ? (hold_r << BEAT) : (hold_r >> BEAT);
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        hold_nxt_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, beat counter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      hold_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

endmodule

// File: tb/tb_p_word_serializer.sv
// Self-checking bench for p_word_serializer: an LSB-first and an MSB-first
// instance share all inputs; a queue-of-beats model predicts both outputs.
module tb_p_word_serializer;

  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic [47:0] in_data = 48'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_last, busy;
  logic [15:0] out_data;
  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [15:0] m_out_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] lsb;
    logic [15:0] msb;
    logic        last;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  p_word_serializer #(.WIDTH(48), .BEAT(16), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  p_word_serializer #(.WIDTH(48), .BEAT(16), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_last(m_out_last), .out_ready(out_ready), .busy(m_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word turns into NB queued beats; one beat leaves per fire.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit rdy  = ce && (q.size() == 0 || (q.size() == 1 && out_ready));
      automatic bit acc  = in_valid && rdy;
      automatic bit fire = ce && (q.size() != 0) && out_ready;
      automatic logic [47:0] w = in_data;
      if (fire) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < NB; i++) begin
          automatic beat_t b;
          b.lsb  = w[16*i +: 16];
          b.msb  = w[16*(NB-1-i) +: 16];
          b.last = (i == NB - 1);
          q.push_back(b);
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_m_out_data", 64'(m_out_data), 64'd0);
    end else begin
      automatic bit rdy = ce && (q.size() == 0 || (q.size() == 1 && out_ready));
      automatic bit vld = (q.size() != 0);
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("m_in_ready", 64'(m_in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(vld));
      chk("m_out_valid", 64'(m_out_valid), 64'(vld));
      chk("busy", 64'(busy), 64'(vld));
      chk("m_busy", 64'(m_busy), 64'(vld));
      if (vld) begin
        chk("out_data", 64'(out_data), 64'(q[0].lsb));
        chk("m_out_data", 64'(m_out_data), 64'(q[0].msb));
        chk("out_last", 64'(out_last), 64'(q[0].last));
        chk("m_out_last", 64'(m_out_last), 64'(q[0].last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_lit(input string name, input logic [15:0] lsb,
                          input logic [15:0] msb, input logic last);
    @(negedge clk);
    chk({name, "_lsb"}, 64'(out_data), 64'(lsb));
    chk({name, "_msb"}, 64'(m_out_data), 64'(msb));
    chk({name, "_last"}, 64'(out_last), 64'(last));
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic [47:0] wa, wb, wn;
    logic [95:0] ab;

    // 1 reset with in_valid high
    in_valid = 1'b1;
    in_data  = 48'h1111_2222_3333;
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_out_data", 64'(out_data), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_release_in_ready", 64'(in_ready), 64'd1);

    // 2 single word, both orders
    step();
    in_data = 48'h0123_4567_89AB;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    beat_lit("t2_b0", 16'h89AB, 16'h0123, 1'b0);
    beat_lit("t2_b1", 16'h4567, 16'h4567, 1'b0);
    beat_lit("t2_b2", 16'h0123, 16'h89AB, 1'b1);
    @(negedge clk);
    chk("t2_idle", 64'(out_valid), 64'd0);

    // 3 backpressure on beat 1
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_data", 64'(out_data), 64'h4567);
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
    end
    step();
    out_ready = 1'b1;
    beat_lit("t3_b1", 16'h4567, 16'h4567, 1'b0);
    beat_lit("t3_b2", 16'h0123, 16'h89AB, 1'b1);
    step();

    // 4 back-to-back words
    wa = 48'hA5A5_1234_C3C3;
    wb = 48'h0F0F_9876_E1E1;
    ab = {wb, wa};
    in_data = wa;
    in_valid = 1'b1;
    step();
    in_data = wb;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_data", 64'(out_data), 64'(ab[16*i +: 16]));
      chk("t4_last", 64'(out_last), 64'((i == 2) || (i == 5)));
      if (i == 2) begin
        chk("t4_b_accept_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("t4_idle", 64'(out_valid), 64'd0);

    // 5 ce gating mid-word
    step();
    in_data = 48'h0123_4567_89AB;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_lit("t5_b0", 16'h89AB, 16'h0123, 1'b0);
    step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_ce_data", 64'(out_data), 64'h4567);
      chk("t5_ce_in_ready", 64'(in_ready), 64'd0);
      chk("t5_ce_valid", 64'(out_valid), 64'd1);
    end
    step();
    ce = 1'b1;
    beat_lit("t5_b1", 16'h4567, 16'h4567, 1'b0);
    beat_lit("t5_b2", 16'h0123, 16'h89AB, 1'b1);
    step();

    // 6 reset mid-word
    in_data = 48'hFFFF_0000_AAAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_lit("t6_b0", 16'hAAAA, 16'hFFFF, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_data", 64'(out_data), 64'd0);
    step();
    rst_n = 1'b1;
    wn = 48'h5555_6666_7777;
    in_data = wn;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_lit("t6_new_b0", 16'h7777, 16'h5555, 1'b0);
    beat_lit("t6_new_b1", 16'h6666, 16'h6666, 1'b0);
    beat_lit("t6_new_b2", 16'h5555, 16'h7777, 1'b1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {16'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 7) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
